// File: rtl/gpio_uart_tx.sv
// gpio_uart_tx: captures bytes strobed out of the processor GPIO port on the
// falling edge of gpio_en, queues them in a small FIFO and streams them out
// as 8N1 UART frames on tx. Consecutive queued bytes are sent back-to-back.
module gpio_uart_tx #(
  parameter int CLKS_PER_BIT = 434,
  parameter int DEPTH        = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [7:0]               gpio,
  input  logic                     gpio_en,
  output logic                     tx,
  output logic                     busy,
  output logic                     overflow,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t             state;
  logic               en_q;
  logic               capture;
  logic               push;
  logic               pop;
  logic               bit_done;
  logic [7:0]         mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   cnt;
  logic [2:0]         idx;
  logic [7:0]         shift;

  // A byte is presented on the high-to-low transition of the strobe.
  assign capture  = en_q && !gpio_en;
  assign bit_done = (cnt == CNT_MAX);

  // The head leaves the FIFO when an idle transmitter starts, or when a stop
  // bit ends with more data waiting (back-to-back frames).
  assign pop  = (level != '0) && ((state == IDLE) || (state == STOP && bit_done));
  // A full FIFO still takes a byte if the head is leaving in the same cycle.
  assign push = capture && ((level != LVL_FULL) || pop);

  assign busy = (state != IDLE);

  // Strobe edge detector, FIFO pointers, occupancy and sticky overflow flag.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others, matching the hardware.
    if (!rst) begin
      en_q     <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      overflow <= 1'b0;
    end else begin
      en_q <= gpio_en;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (capture && !push) overflow <= 1'b1;
      unique case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  // FIFO storage write port.
  always_ff @(posedge clk) begin
    // NOTE: the storage array has no reset; the pointers and level define
    // which entries are valid, so stale contents are never observed.
    if (push) mem[wr_ptr] <= gpio;
  end

  // Transmit FSM: start bit, eight data bits LSB first, stop bit; tx is a
  // register so the line never glitches.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
      idx   <= '0;
      shift <= '0;
      tx    <= 1'b1;
    end else begin
      unique case (state)
        IDLE: begin
          tx <= 1'b1;
          if (pop) begin
            shift <= mem[rd_ptr];
            cnt   <= '0;
            tx    <= 1'b0;
            state <= START;
          end
        end
        START: begin
          if (bit_done) begin
            cnt   <= '0;
            idx   <= '0;
            tx    <= shift[0];
            state <= DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DATA: begin
          if (bit_done) begin
            cnt   <= '0;
            shift <= {1'b0, shift[7:1]};
            if (idx == 3'd7) begin
              tx    <= 1'b1;
              state <= STOP;
            end else begin
              idx <= idx + 1'b1;
              tx  <= shift[1];
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        STOP: begin
          if (bit_done) begin
            cnt <= '0;
            if (pop) begin
              shift <= mem[rd_ptr];
              tx    <= 1'b0;
              state <= START;
            end else begin
              state <= IDLE;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/gpio_uart_tx.md
# gpio_uart_tx

Downstream consumer of the processor's GPIO byte port. Captures each byte the processor presents on `gpio` at the falling edge of `gpio_en`, buffers it in a small FIFO, and serialises it as 8N1 UART on `tx`. Simulation and FPGA builds can then stream program output off-chip without stalling the core.

## Interface
- `CLKS_PER_BIT`, 434: clock cycles per UART bit; legal range ≥2. 434 gives 115200 baud at 50 MHz.
- `DEPTH`, 16: FIFO entries; must be a power of two, ≥2.

- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `gpio`  in  8  byte from the processor GPIO port.
- `gpio_en`  in  1  processor GPIO strobe; a byte is valid on its high-to-low transition.
- `tx`  out  1  UART serial line, idle high.
- `busy`  out  1  high while a frame is in progress (FSM not IDLE).
- `overflow`  out  1  sticky; set when a byte is dropped because the FIFO is full.
- `level`  out  $clog2(DEPTH)+1  current FIFO occupancy, 0..DEPTH.

## Operation
- Edge detect: `en_q` registers `gpio_en` every cycle. A capture occurs in any cycle where `en_q`=1 and `gpio_en`=0.
- Data sampling: `gpio` is sampled in the capture cycle. Upstream holds `gpio` stable for at least one cycle after `gpio_en` falls.
- Push rule:
  - A byte is written when `level`<DEPTH, or when a pop occurs in the same cycle.
  - Otherwise the byte is dropped and `overflow` is set. `overflow` stays set until reset.
- FIFO: circular buffer with read and write pointers of $clog2(DEPTH) bits that wrap modulo DEPTH. `level` is maintained as follows:
  - +1 on push only.
  - −1 on pop only.
  - Unchanged when push and pop occur together.
- TX FSM states: IDLE, START, DATA, STOP. A bit counter runs 0..CLKS_PER_BIT−1 and a 3-bit index tracks the data bit.
  - IDLE: `tx`=1. If `level`>0, pop the head into the shift register, clear the counter, and go to START.
  - START: `tx`=0 for CLKS_PER_BIT cycles, then go to DATA with index 0.
  - DATA: `tx`=shift[0], sending LSB first. Each bit lasts CLKS_PER_BIT cycles, then the register shifts right and the index increments. After index 7 completes, go to STOP.
  - STOP: `tx`=1 for CLKS_PER_BIT cycles. At the end:
    - If `level`>0, pop and go directly to START (back-to-back frames, no idle gap).
    - Otherwise go to IDLE.
- `tx` is driven from a register (glitch-free).
- `busy` = (state != IDLE).

## Timing
- Reset values (applied asynchronously while `rst`=0):
  - `tx`=1, `busy`=0, `overflow`=0, `level`=0.
  - `en_q`=0, state IDLE, pointers 0.
- A `gpio_en` that is high when reset releases does not generate a capture.
- Reset asserted mid-frame aborts the frame: `tx` goes high immediately and all buffered bytes are discarded.
- Let E be the rising edge that samples the capture cycle. Then:
  - `level` increments after E.
  - If the FSM is IDLE with an empty FIFO, the pop happens at E+1; `tx` falls and `busy` rises after E+1.
- Frame length is exactly 10·CLKS_PER_BIT cycles. Consecutive queued bytes follow with zero gap.
- Captures are accepted every cycle the edge condition holds. The fastest legal strobe is high 1 cycle, low 1 cycle, i.e. one capture every 2 cycles.
- A push into a full FIFO in the same cycle as the STOP→START or IDLE→START pop is accepted; `level` stays at DEPTH.

## Test plan
Benches use CLKS_PER_BIT=4 and DEPTH=4.

- **Reset:** hold `rst`=0 with `gpio_en`=1, then release → `tx`=1, `busy`=0, `level`=0, `overflow`=0, and no capture for 20 cycles.
- **Single byte:** send `gpio`=8'hA5 with a 1→0 pulse on `gpio_en` → `level`=1 after E, 0 after E+1. `tx` sequence in 4-cycle bits: 0,1,0,1,0,0,1,0,1,1. `busy` is high for exactly 40 cycles.
- **Back-to-back:** push 8'h01, 8'h02, 8'h03 two cycles apart → three frames with no idle cycle between them, 120 cycles of `busy`, payloads LSB-first 01,02,03.
- **Overflow:** push 6 bytes 8'h10..8'h15 two cycles apart while the first frame is active → `level` peaks at 4 and `overflow`=1. The bytes transmitted are exactly 10, 11, 12, 13, 14 (the first is popped, so the fifth fits); 15 is dropped.
- **Push at full during pop:** fill the FIFO to 4 and time a capture on the STOP→START edge → byte accepted, `level` stays 4, `overflow` stays 0.
- **Mid-frame reset:** assert `rst` during DATA bit 3 of 8'hFF with 2 bytes queued → `tx`=1 immediately, `level`=0, `busy`=0. No frame follows after release.
